// File: rtl/requant_pack.sv
// Requantizes signed 32-bit accumulator results to int8 (multiply, round-shift, clamp)
// and packs four lanes per 32-bit word into a first-word-fall-through output FIFO.
module requant_pack #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  input  logic [15:0] scale_i,
  input  logic [4:0]  shift_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  input  logic        ready_i,
  output logic        sat_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = AW + 2;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  // Stage 1: operands captured on accept
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q, s1_data_d;
  logic [15:0] s1_scale_q, s1_scale_d;
  logic [4:0]  s1_shift_q, s1_shift_d;

  // Stage 2: product and its shift amount
  logic               s2_valid_q, s2_valid_d;
  logic signed [47:0] s2_prod_q, s2_prod_d;
  logic [4:0]         s2_shift_q, s2_shift_d;

  // Packer and control
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        flush_pending_q, flush_pending_d;
  logic        sat_q, sat_d;

  // Output FIFO
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic [31:0]        push_data;
  logic               flush_fire;
  logic signed [47:0] prod;
  logic signed [47:0] bias;
  logic signed [47:0] rounded;
  logic [7:0]         lane_byte;
  logic               clamped;
  logic [OW-1:0]      occupancy;

  // Occupancy counts in-flight values as if each could become a word, so a push
  // from stage 2 always finds room without backpressuring the pipeline.
  always_comb begin
    occupancy = OW'(count_q) + OW'(s1_valid_q) + OW'(s2_valid_q);
  end

  assign ready_o = !rst_i && !flush_pending_q && (occupancy < OW'(FIFO_DEPTH));
  assign accept  = valid_i && ready_o;
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign pop     = valid_o && ready_i;
  assign sat_o   = sat_q;

  always_comb begin
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    s1_scale_d = s1_scale_q;
    s1_shift_d = s1_shift_q;
    if (accept) begin
      s1_data_d  = data_i;
      s1_scale_d = scale_i;
      s1_shift_d = shift_i;
    end
  end

  always_comb begin
    prod = $signed({{16{s1_data_q[31]}}, s1_data_q}) * $signed({32'd0, s1_scale_q});
    s2_valid_d = s1_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_shift_d = s2_shift_q;
    if (s1_valid_q) begin
      s2_prod_d  = prod;
      s2_shift_d = s1_shift_q;
    end
  end

  // Round half up; with shift 0 the bias is zero and the shift is a no-op.
  always_comb begin
    bias = '0;
    if (s2_shift_q != 5'd0) begin
      bias[s2_shift_q - 5'd1] = 1'b1;
    end
    rounded = (s2_prod_q + bias) >>> s2_shift_q;
    clamped = 1'b0;
    if (rounded > 48'sd127) begin
      lane_byte = 8'h7F;
      clamped   = 1'b1;
    end else if (rounded < -48'sd128) begin
      lane_byte = 8'h80;
      clamped   = 1'b1;
    end else begin
      lane_byte = rounded[7:0];
    end
  end

  assign flush_fire = flush_pending_q && !s1_valid_q && !s2_valid_q;

  always_comb begin
    push            = 1'b0;
    push_data       = word_q;
    lane_d          = lane_q;
    word_d          = word_q;
    sat_d           = sat_q;
    flush_pending_d = flush_pending_q;
    if (s2_valid_q) begin
      sat_d = sat_q | clamped;
      if (lane_q == 2'd3) begin
        push      = 1'b1;
        push_data = {lane_byte, word_q[23:0]};
        word_d    = '0;
        lane_d    = 2'd0;
      end else begin
        word_d[8*lane_q +: 8] = lane_byte;
        lane_d                = lane_q + 2'd1;
      end
    end else if (flush_fire) begin
      if (lane_q != 2'd0) begin
        push      = 1'b1;
        push_data = word_q;
        word_d    = '0;
        lane_d    = 2'd0;
      end
      flush_pending_d = 1'b0;
    end
    if (!flush_pending_q && flush_i) begin
      flush_pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q      <= 1'b0;
      s1_data_q       <= '0;
      s1_scale_q      <= '0;
      s1_shift_q      <= '0;
      s2_valid_q      <= 1'b0;
      s2_prod_q       <= '0;
      s2_shift_q      <= '0;
      lane_q          <= '0;
      word_q          <= '0;
      flush_pending_q <= 1'b0;
      sat_q           <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_data_q       <= s1_data_d;
      s1_scale_q      <= s1_scale_d;
      s1_shift_q      <= s1_shift_d;
      s2_valid_q      <= s2_valid_d;
      s2_prod_q       <= s2_prod_d;
      s2_shift_q      <= s2_shift_d;
      lane_q          <= lane_d;
      word_q          <= word_d;
      flush_pending_q <= flush_pending_d;
      sat_q           <= sat_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: doc/requant_pack.md
REQUANT_PACK -- requirements
Module: requant_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state rising-edge triggered.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  accumulated result valid (from accumulator read path).
REQ-005 SHALL have port data_i  input  32  signed accumulated result, zero point already added.
REQ-006 SHALL have port ready_o  output  1  block can accept data_i this cycle.
REQ-007 SHALL have port scale_i  input  16  unsigned requant multiplier.
REQ-008 SHALL have port shift_i  input  5  arithmetic right shift amount, 0..31.
REQ-009 SHALL have port flush_i  input  1  single-cycle request to emit a partially packed word.
REQ-010 SHALL have port valid_o  output  1  packed word available.
REQ-011 SHALL have port data_o  output  32  packed int8 word, lane 0 in bits [7:0].
REQ-012 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-013 SHALL have port sat_o  output  1  sticky: some accepted value clamped.

Function
REQ-014 SHALL accept an input only in a cycle with valid_i=1 and ready_o=1; scale_i and shift_i are sampled with it and travel with the value.
REQ-015 SHALL compute in stage 1 a 48-bit signed product: signed(data_i) * zero-extended scale_i.
REQ-016 SHALL compute in stage 2: if shift=0 then r=product, else r=(product + 2^(shift-1)) >>> shift (arithmetic, 48-bit, no wrap).
REQ-017 SHALL clamp r to [-128,127], keep the low 8 bits as two's complement, and set sat_o when clamping changed the value.
REQ-018 SHALL place successive bytes in lanes 0,1,2,3 per a 2-bit lane counter; at lane 3 the word is pushed to the FIFO and the counter wraps to 0.
REQ-019 SHALL meet this latency: value accepted in cycle t occupies stage 1 in t+1 and stage 2 in t+2; if it completes a word, valid_o=1 with that word in cycle t+3 when the FIFO was empty.
REQ-020 SHALL drive ready_o = !flush_pending && (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH, from registers only, so a FIFO push is never refused.
REQ-021 SHALL present the FIFO head on data_o/valid_o (first-word fall-through) and pop it on valid_o && ready_i.
REQ-022 SHALL allow a FIFO push and pop in the same cycle, including when the FIFO is full.
REQ-023 SHALL keep data_o stable while valid_o=1 and ready_i=0, and SHALL drive data_o=0 when the FIFO is empty.
REQ-024 SHALL preserve strict input order; no word may be dropped or duplicated.
REQ-025 SHALL set flush_pending on flush_i=1; a flush_i arriving while flush_pending is already set is ignored.
REQ-026 SHALL hold ready_o=0 while flush_pending=1, and SHALL take this action once stage 1 and stage 2 are both empty:
- lane counter != 0: push the partial word, unused upper lanes 0, clear the counter, clear flush_pending;
- lane counter = 0: clear flush_pending only, no push.
REQ-027 SHALL, when flush_i coincides with an accepted input, pack that input before the flush executes.
REQ-028 SHALL clear sat_o only on reset.

Reset
REQ-029 SHALL, on rst_i=1 at any time, asynchronously clear:
- all pipeline valids;
- the lane counter and the partial word;
- the FIFO pointers and count;
- flush_pending and sat_o.
REQ-030 SHALL hold these output values during reset: valid_o=0, data_o=0, sat_o=0, ready_o=0.
REQ-031 SHALL discard any in-flight data on reset, and SHALL assert ready_o=1 in the first cycle after rst_i deasserts.

Verification
REQ-032 SHALL be checked with scale=1, shift=0, inputs 1,2,3,4 in consecutive cycles (4 accepted at t), ready_i=1 -> data_o=0x04030201, valid_o=1 in cycle t+3, sat_o=0.
REQ-033 SHALL be checked with scale=1, shift=0, inputs -300,1000,-128,127 -> data_o=0x7F807F80, sat_o=1.
REQ-034 SHALL be checked with scale=3, shift=2, inputs 5,-5,6,0 -> bytes 0x04,0xFC,0x05,0x00 -> data_o=0x0005FC04.
REQ-035 SHALL be checked with inputs 0x11,0x22 (scale=1, shift=0), then a flush_i pulse -> one word 0x00002211; a second flush with the lane counter at 0 -> no word.
REQ-036 SHALL be checked with ready_i=0 while 24 inputs are offered -> ready_o falls when fifo_count+in-flight reaches FIFO_DEPTH; after ready_i=1, all 6 words arrive in order, no loss.
REQ-037 SHALL be checked with rst_i pulsed after 2 bytes are packed and 1 is in flight -> valid_o=0; the next 4 inputs form a fresh word starting at lane 0.
